onehot_mux_pipe: RTL and testbench

ONEHOT_MUX_PIPE -- requirements
Module: onehot_mux_pipe

---
 rtl/onehot_mux_pipe_if.sv | 29 ++
 rtl/onehot_mux_pipe.sv | 91 +++++++++
 tb/tb_onehot_mux_pipe.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_mux_pipe_if.sv
// rtl/onehot_mux_pipe_if.sv - request/result bundle for the one-hot channel mux pipe
interface onehot_mux_pipe_if #(
   parameter int CHANNELS = 4,
   parameter int DATA_W   = 8
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                       in_valid;
   logic                       in_ready;
   logic [CHANNELS-1:0]        select;
   logic [CHANNELS*DATA_W-1:0] data_in;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_W-1:0]          data_out;
   logic [CW-1:0]              out_chan;
   logic                       out_err;
   logic                       clr_err;
   logic [7:0]                 err_count;

   modport master (
      output in_valid, select, data_in, out_ready, clr_err,
      input  in_ready, out_valid, data_out, out_chan, out_err, err_count
   );

   modport slave (
      input  in_valid, select, data_in, out_ready, clr_err,
      output in_ready, out_valid, data_out, out_chan, out_err, err_count
   );
endinterface

// File: rtl/onehot_mux_pipe.sv
// rtl/onehot_mux_pipe.sv - one-hot channel select mux with a single registered output stage
module onehot_mux_pipe #(
   parameter int CHANNELS      = 4,
   parameter int DATA_W        = 8,
   parameter int PRIORITY_MODE = 0
) (
   input logic              clk,
   input logic              rst,
   onehot_mux_pipe_if.slave bus
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CHANNELS-1:0] ONE = CHANNELS'(1);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CW-1:0]     chan_q, chan_d;
   logic              err_q, err_d;
   logic [7:0]        cnt_q, cnt_d;

   logic [CW-1:0]     low_idx;
   logic              sel_none;
   logic              sel_multi;
   logic              sel_err;
   logic [DATA_W-1:0] sel_data;
   logic              xfer;

   assign bus.in_ready = !valid_q || bus.out_ready;
   assign xfer         = bus.in_valid && bus.in_ready;

   // Descending scan leaves the lowest set index; it only matters when the select is legal.
   always_comb begin
      low_idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (bus.select[i]) begin
            low_idx = CW'(i);
         end
      end
      sel_none  = (bus.select == '0);
      sel_multi = ((bus.select & (bus.select - ONE)) != '0);
      sel_err   = sel_none || (sel_multi && (PRIORITY_MODE == 0));
      sel_data  = bus.data_in[int'(low_idx)*DATA_W +: DATA_W];
      if (sel_err) begin
         sel_data = '0;
         low_idx  = '0;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      chan_d  = chan_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (xfer) begin
         valid_d = 1'b1;
         data_d  = sel_data;
         chan_d  = low_idx;
         err_d   = sel_err;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
      // A clear that lands on an erroring transfer still records that one error.
      if (bus.clr_err) begin
         cnt_d = (xfer && sel_err) ? 8'd1 : 8'd0;
      end else if (xfer && sel_err && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         chan_q  <= chan_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.data_out  = data_q;
   assign bus.out_chan  = chan_q;
   assign bus.out_err   = err_q;
   assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_onehot_mux_pipe.sv
// tb/tb_onehot_mux_pipe.sv - randomized self-checking bench for onehot_mux_pipe in both select modes
module tb_onehot_mux_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  select = 4'h0;
   logic [31:0] data_in = 32'h0;
   logic        out_ready = 1'b0;
   logic        clr_err = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   onehot_mux_pipe_if #(.CHANNELS(4), .DATA_W(8)) bus0 ();
   onehot_mux_pipe_if #(.CHANNELS(4), .DATA_W(8)) bus1 ();

   assign bus0.in_valid  = in_valid;
   assign bus0.select    = select;
   assign bus0.data_in   = data_in;
   assign bus0.out_ready = out_ready;
   assign bus0.clr_err   = clr_err;
   assign bus1.in_valid  = in_valid;
   assign bus1.select    = select;
   assign bus1.data_in   = data_in;
   assign bus1.out_ready = out_ready;
   assign bus1.clr_err   = clr_err;

   onehot_mux_pipe #(.CHANNELS(4), .DATA_W(8), .PRIORITY_MODE(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );
   onehot_mux_pipe #(.CHANNELS(4), .DATA_W(8), .PRIORITY_MODE(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   logic [1:0] g_ir, g_ov, g_oe;
   logic [7:0] g_data [2];
   logic [1:0] g_chan [2];
   logic [7:0] g_cnt  [2];
   assign g_ir      = {bus1.in_ready, bus0.in_ready};
   assign g_ov      = {bus1.out_valid, bus0.out_valid};
   assign g_oe      = {bus1.out_err, bus0.out_err};
   assign g_data[0] = bus0.data_out;
   assign g_data[1] = bus1.data_out;
   assign g_chan[0] = bus0.out_chan;
   assign g_chan[1] = bus1.out_chan;
   assign g_cnt[0]  = bus0.err_count;
   assign g_cnt[1]  = bus1.err_count;

   logic       m_valid [2];
   logic [7:0] m_data  [2];
   int         m_chan  [2];
   logic       m_err   [2];
   int         m_cnt   [2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void ref_sel(input int mode, input logic [3:0] sel, input logic [31:0] din,
                                   output logic [7:0] d, output int ch, output logic e);
      int ones;
      int low;
      ones = 0;
      low  = -1;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) begin
            ones++;
            if (low < 0) low = i;
         end
      end
      if (ones == 0 || (ones > 1 && mode == 0)) begin
         d = 8'h00; ch = 0; e = 1'b1;
      end else begin
         d = din[low*8 +: 8]; ch = low; e = 1'b0;
      end
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_valid[m] = 1'b0; m_data[m] = 8'h00; m_chan[m] = 0; m_err[m] = 1'b0; m_cnt[m] = 0;
      end
   endtask

   task automatic check_outputs(input string ctx);
      for (int m = 0; m < 2; m++) begin
         check_eq($sformatf("%s out_valid m%0d", ctx, m), 32'(g_ov[m]), 32'(m_valid[m]));
         check_eq($sformatf("%s err_count m%0d", ctx, m), 32'(g_cnt[m]), 32'(m_cnt[m]));
         if (m_valid[m]) begin
            check_eq($sformatf("%s data_out m%0d", ctx, m), 32'(g_data[m]), 32'(m_data[m]));
            check_eq($sformatf("%s out_chan m%0d", ctx, m), 32'(g_chan[m]), 32'(m_chan[m]));
            check_eq($sformatf("%s out_err m%0d", ctx, m), 32'(g_oe[m]), 32'(m_err[m]));
         end
      end
   endtask

   // Inputs are set just after an edge; this checks in_ready, clocks once and checks the result.
   task automatic step(input string ctx);
      logic [7:0] d;
      int         ch;
      logic       e;
      logic       rdy;
      logic       xfer;
      logic       nv [2];
      logic [7:0] nd [2];
      int         nc [2];
      logic       ne [2];
      int         ncnt [2];
      #1;
      for (int m = 0; m < 2; m++) begin
         rdy = !m_valid[m] || out_ready;
         check_eq($sformatf("%s in_ready m%0d", ctx, m), 32'(g_ir[m]), 32'(rdy));
         xfer = in_valid && rdy;
         ref_sel(m, select, data_in, d, ch, e);
         nv[m] = m_valid[m]; nd[m] = m_data[m]; nc[m] = m_chan[m]; ne[m] = m_err[m];
         if (xfer) begin
            nv[m] = 1'b1; nd[m] = d; nc[m] = ch; ne[m] = e;
         end else if (out_ready) begin
            nv[m] = 1'b0;
         end
         ncnt[m] = m_cnt[m];
         if (clr_err) ncnt[m] = (xfer && e) ? 1 : 0;
         else if (xfer && e && m_cnt[m] < 255) ncnt[m] = m_cnt[m] + 1;
      end
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         m_valid[m] = nv[m]; m_data[m] = nd[m]; m_chan[m] = nc[m]; m_err[m] = ne[m]; m_cnt[m] = ncnt[m];
      end
      check_outputs(ctx);
   endtask

   task automatic check_reset_state(input string ctx);
      for (int m = 0; m < 2; m++) begin
         check_eq($sformatf("%s rst out_valid m%0d", ctx, m), 32'(g_ov[m]), 32'd0);
         check_eq($sformatf("%s rst data_out m%0d", ctx, m), 32'(g_data[m]), 32'd0);
         check_eq($sformatf("%s rst out_chan m%0d", ctx, m), 32'(g_chan[m]), 32'd0);
         check_eq($sformatf("%s rst out_err m%0d", ctx, m), 32'(g_oe[m]), 32'd0);
         check_eq($sformatf("%s rst err_count m%0d", ctx, m), 32'(g_cnt[m]), 32'd0);
         check_eq($sformatf("%s rst in_ready m%0d", ctx, m), 32'(g_ir[m]), 32'd1);
      end
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #1 check_reset_state("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("post_rst");

      // Single legal select
      data_in = 32'hDDCCBBAA; select = 4'b0100; in_valid = 1'b1; out_ready = 1'b1;
      step("sel2");
      check_eq("sel2 data const", 32'(bus0.data_out), 32'hCC);
      check_eq("sel2 chan const", 32'(bus0.out_chan), 32'd2);

      // Empty then multi-hot, back to back
      select = 4'b0000;
      step("none");
      select = 4'b0110;
      step("multi");
      check_eq("multi m0 err const", 32'(bus0.out_err), 32'd1);
      check_eq("multi m0 cnt const", 32'(bus0.err_count), 32'd2);
      check_eq("multi m1 data const", 32'(bus1.data_out), 32'hBB);
      check_eq("multi m1 chan const", 32'(bus1.out_chan), 32'd1);
      check_eq("multi m1 cnt const", 32'(bus1.err_count), 32'd1);

      // Stall for three cycles while the inputs move
      select = 4'b0001; data_in = 32'h44332211;
      step("pre_stall");
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         select = 4'(1 << k); data_in = $urandom;
         step($sformatf("stall%0d", k));
         check_eq($sformatf("stall%0d data const", k), 32'(bus0.data_out), 32'h11);
      end
      out_ready = 1'b1;
      step("unstall");

      // Counter saturation then clear alongside one more error
      select = 4'b0000;
      for (int k = 0; k < 256; k++) step("sat");
      check_eq("sat m0 cnt const", 32'(bus0.err_count), 32'd255);
      check_eq("sat m1 cnt const", 32'(bus1.err_count), 32'd255);
      clr_err = 1'b1;
      step("clr_err");
      clr_err = 1'b0;
      check_eq("clr m0 cnt const", 32'(bus0.err_count), 32'd1);
      check_eq("clr m1 cnt const", 32'(bus1.err_count), 32'd1);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         clr_err   = ($urandom_range(0, 19) == 0);
         data_in   = $urandom;
         case ($urandom_range(0, 3))
            0, 1:    select = 4'(1 << $urandom_range(0, 3));
            2:       select = 4'b0000;
            default: select = 4'($urandom);
         endcase
         step("rand");
      end

      // Reset pulse during a stall
      clr_err = 1'b0; in_valid = 1'b1; out_ready = 1'b0; select = 4'b0000;
      step("stall_err");
      if (m_valid[0]) step("stall_err2");
      @(negedge clk);
      rst = 1'b1;
      #1 check_reset_state("mid_stall");
      #2 rst = 1'b0;
      model_reset();
      in_valid = 1'b0; out_ready = 1'b1;
      step("after_rst0");
      step("after_rst1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
